// File: rtl/mem_write_bus.sv
// Write-side bank bus for the two dual-port data memories.
// Result writes are queued in an in-order FIFO and retired one per cycle
// to their bank whenever that bank's port carries no read.
module mem_write_bus #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [ADDR_WIDTH+1:0]     wr_addr,
  input  logic                      wr_bia,
  input  logic [63:0]               wr_data,
  input  logic [3:0]                bank_rd_busy,
  output logic [3:0]                bank_we,
  output logic [4*ADDR_WIDTH-1:0]   bank_waddr,
  output logic [255:0]              bank_wdata,
  output logic [$clog2(DEPTH):0]    wr_count,
  output logic                      wr_empty,
  output logic                      wr_prio
);

  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned FW = ADDR_WIDTH + 2;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [SW-1:0] LIM  = SW'(STARVE_LIM);

  logic [FW-1:0] r_addr [DEPTH];
  logic [63:0]   r_data [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve;
  logic          r_prio;

  logic          w_push;
  logic          w_pop;
  logic          w_head_vld;
  logic          w_head_blk;
  logic [FW-1:0] w_eff;
  logic [FW-1:0] w_head_addr;
  logic [1:0]    w_bank;
  logic [CW-1:0] w_count_nxt;
  logic [SW-1:0] w_starve_nxt;

  // Ready depends only on the registered count, so a full FIFO never pushes through.
  assign wr_ready    = !rst && (r_count < FULL);
  assign w_push      = wr_valid && wr_ready;
  // bia increment applies to bank+word as one field, so a word carry moves to the next bank.
  assign w_eff       = wr_addr + FW'(wr_bia);

  // Head is suppressed during reset so no pending entry is issued on the reset cycle.
  assign w_head_vld  = !rst && (r_count != '0);
  assign w_head_addr = r_addr[r_rptr];
  assign w_bank      = w_head_addr[FW-1:AW];
  assign w_head_blk  = bank_rd_busy[w_bank];
  assign w_pop       = w_head_vld && !w_head_blk;

  assign wr_count = r_count;
  assign wr_empty = (r_count == '0);
  assign wr_prio  = r_prio;

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wptr] <= w_eff;
      r_data[r_wptr] <= wr_data;
    end
  end

  // Occupancy after this cycle's push/pop
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Consecutive blocked cycles of the current head, saturating at the limit
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_pop || !w_head_vld) begin
      w_starve_nxt = '0;
    end else if (r_starve != LIM) begin
      w_starve_nxt = r_starve + SW'(1);
    end
  end

  // Pointer, count, starvation and priority registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_prio   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_count  <= w_count_nxt;
      r_starve <= w_starve_nxt;
      r_prio   <= (w_starve_nxt == LIM) && (w_count_nxt != '0);
    end
  end

  // Route the FIFO head onto its bank's slice; other slices stay zero
  always_comb begin
    bank_we    = '0;
    bank_waddr = '0;
    bank_wdata = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      if (w_head_vld && (w_bank == 2'(b))) begin
        bank_we[b]               = !w_head_blk;
        bank_waddr[b*AW +: AW]   = w_head_addr[AW-1:0];
        bank_wdata[b*64 +: 64]   = r_data[r_rptr];
      end
    end
  end

endmodule
